// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial link blocks.
// The SIPO harness uses WORD_WIDTH too, so both ends agree on the word size.
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned WORD_WIDTH = 4;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: takes a word over valid/ready and drives it
// out LSB first, one bit per clock, streaming back-to-back words with no gap.
//
// state | meaning
// IDLE  | line parked at 0, ready for a word
// SHIFT | sreg_q[0] on data, cnt_q = index of the bit on the line
module piso_tx
    import serdes_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             data,
    output logic             first,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sreg_q;
    logic               done_q;

    logic               at_last;
    logic               handshake;

    assign at_last   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    // Ready again on the last bit so the next word follows without a bubble.
    assign din_ready = !rst && ((state_q == IDLE) || at_last);
    assign handshake = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= at_last;
            if (handshake) begin
                state_q <= SHIFT;
                cnt_q   <= '0;
                sreg_q  <= din;
            end else if (state_q == SHIFT) begin
                sreg_q <= sreg_q >> 1;
                if (at_last) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign busy  = (state_q == SHIFT);
    assign data  = busy && sreg_q[0];
    assign first = busy && (cnt_q == '0);
    assign last  = at_last;
    assign done  = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a WIDTH=4 instance checked by a word scoreboard plus directed
// cycle checks, and a WIDTH=8 instance for the wide-word case.
module tb_piso_tx;
    import serdes_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] din4;
    logic       vld4, rdy4, data4, first4, last4, busy4, done4;
    logic [7:0] din8;
    logic       vld8, rdy8, data8, first8, last8, busy8, done8;

    piso_tx #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .din(din4), .din_valid(vld4), .din_ready(rdy4),
        .data(data4), .first(first4), .last(last4), .busy(busy4), .done(done4)
    );

    piso_tx #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .din(din8), .din_valid(vld8), .din_ready(rdy8),
        .data(data8), .first(first8), .last(last8), .busy(busy8), .done(done8)
    );

    int checks = 0;
    int errors = 0;
    int nwords = 0;
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Downstream SIPO model: shifts in at the top so LSB-first bits land in place.
    logic [3:0] sipo;
    always @(posedge clk) sipo <= {data4, sipo[3:1]};

    // Monitor: rebuild each word from the line and compare with the scoreboard.
    logic [3:0] acc;
    int         nbits;
    logic       last_prev;
    logic [3:0] word_prev;
    initial begin
        acc = '0; nbits = 0; last_prev = 1'b0; word_prev = '0;
    end

    always @(negedge clk) begin
        chk("done_timing", 32'(done4), 32'(last_prev));
        if (done4 && last_prev) chk("sipo_word", 32'(sipo), 32'(word_prev));
        last_prev = 1'b0;
        if (busy4) begin
            if (first4) begin
                acc   = '0;
                nbits = 0;
            end
            if (nbits < 4) acc[nbits[1:0]] = data4;
            nbits++;
            if (last4) begin
                chk("word_bits", 32'(nbits), 32'd4);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word at %0t: got %0h expected none", $time, acc);
                end else begin
                    word_prev = exp_q.pop_front();
                    chk("word", 32'(acc), 32'(word_prev));
                    nwords++;
                end
                last_prev = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy4 && n < 20) begin
            cyc();
            n++;
        end
        chk("idle_timeout", 32'(busy4), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got running expected finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] seq5;
        logic [8:0] seq9;
        logic [8:0] done_m;
        logic [7:0] rdy_m;
        logic [8:0] first_m;

        rst = 1'b1; din4 = '0; vld4 = 1'b0; din8 = '0; vld8 = 1'b0;
        cyc();
        cyc();

        // Reset values.
        chk("rst_data", 32'(data4), 32'd0);
        chk("rst_first", 32'(first4), 32'd0);
        chk("rst_last", 32'(last4), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_ready", 32'(rdy4), 32'd0);

        // Valid during reset is ignored; acceptance on first edge after release.
        vld4 = 1'b1; din4 = 4'h9;
        cyc();
        chk("rstvld_busy", 32'(busy4), 32'd0);
        chk("rstvld_ready", 32'(rdy4), 32'd0);
        chk("rstvld_data", 32'(data4), 32'd0);
        rst = 1'b0;
        exp_q.push_back(4'h9);
        #1;
        chk("rel_ready", 32'(rdy4), 32'd1);
        cyc();
        chk("rel_busy", 32'(busy4), 32'd1);
        chk("rel_first", 32'(first4), 32'd1);
        chk("rel_data", 32'(data4), 32'd1);
        vld4 = 1'b0;
        wait_idle();

        // Single word 1011: line 1,1,0,1 then 0.
        din4 = 4'b1011; vld4 = 1'b1;
        exp_q.push_back(4'hB);
        seq5 = 5'b0_1011;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (c == 0) vld4 = 1'b0;
            chk("single_data", 32'(data4), 32'(seq5[c]));
            chk("single_first", 32'(first4), 32'(c == 0));
            chk("single_last", 32'(last4), 32'(c == 3));
            chk("single_done", 32'(done4), 32'(c == 4));
            chk("single_busy", 32'(busy4), 32'(c < 4));
        end
        wait_idle();

        // Back-to-back A then 5.
        din4 = 4'hA; vld4 = 1'b1;
        exp_q.push_back(4'hA);
        seq9   = 9'h05A;
        rdy_m  = 8'b1000_1000;
        done_m = 9'b1_0001_0000;
        for (int c = 0; c < 9; c++) begin
            cyc();
            chk("b2b_data", 32'(data4), 32'(seq9[c]));
            chk("b2b_done", 32'(done4), 32'(done_m[c]));
            if (c < 8) chk("b2b_ready", 32'(rdy4), 32'(rdy_m[c]));
            if (c == 3) begin
                din4 = 4'h5;
                exp_q.push_back(4'h5);
            end
            if (c == 7) vld4 = 1'b0;
        end
        wait_idle();

        // Stall: 3 waits with valid high while C shifts out.
        din4 = 4'hC; vld4 = 1'b1;
        exp_q.push_back(4'hC);
        seq9    = 9'h03C;
        first_m = 9'b0_0001_0001;
        for (int c = 0; c < 9; c++) begin
            cyc();
            chk("stall_data", 32'(data4), 32'(seq9[c]));
            chk("stall_first", 32'(first4), 32'(first_m[c]));
            chk("stall_done", 32'(done4), 32'(done_m[c]));
            if (c < 8) chk("stall_ready", 32'(rdy4), 32'(rdy_m[c]));
            if (c == 0) begin
                din4 = 4'h3;
                exp_q.push_back(4'h3);
            end
            if (c == 4) vld4 = 1'b0;
        end
        wait_idle();

        // Reset in the middle of F: dropped silently.
        din4 = 4'hF; vld4 = 1'b1;
        cyc();
        chk("midrst_busy0", 32'(busy4), 32'd1);
        vld4 = 1'b0;
        cyc();
        rst = 1'b1;
        vld4 = 1'b1;
        #1;
        chk("midrst_ready_hi", 32'(rdy4), 32'd0);
        cyc();
        chk("midrst_data", 32'(data4), 32'd0);
        chk("midrst_busy", 32'(busy4), 32'd0);
        chk("midrst_ready", 32'(rdy4), 32'd0);
        rst = 1'b0;
        vld4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("midrst_nodone", 32'(done4), 32'd0);
            chk("midrst_idle", 32'(busy4), 32'd0);
        end
        din4 = 4'h6; vld4 = 1'b1;
        exp_q.push_back(4'h6);
        seq5 = 5'b0_0110;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (c == 0) vld4 = 1'b0;
            chk("after_data", 32'(data4), 32'(seq5[c]));
            chk("after_done", 32'(done4), 32'(c == 4));
        end
        wait_idle();

        // WIDTH=8: A5 goes out as 1,0,1,0,0,1,0,1.
        chk("w8_ready", 32'(rdy8), 32'd1);
        din8 = 8'hA5; vld8 = 1'b1;
        seq9 = 9'h0A5;
        for (int c = 0; c < 9; c++) begin
            cyc();
            if (c == 0) vld8 = 1'b0;
            chk("w8_data", 32'(data8), 32'(seq9[c]));
            chk("w8_first", 32'(first8), 32'(c == 0));
            chk("w8_last", 32'(last8), 32'(c == 7));
            chk("w8_done", 32'(done8), 32'(c == 8));
            chk("w8_busy", 32'(busy8), 32'(c < 8));
        end
        cyc();
        chk("w8_done_clear", 32'(done8), 32'd0);

        cyc();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("word_count", 32'(nwords), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
